// File: rtl/bp_me_cache_dma_arbiter_pkg.sv
// Shared types for the cache-slice DMA arbiter.
//   - Simplified BedRock memory header layout and message types.
//   - Command-side and response-side FSM state enums.
//   - Macro declaring the in-order routing tag {slice_id, is_read}.
package bp_me_cache_dma_arbiter_pkg;

  localparam int paddr_width_gp = 40;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [7:0]                payload;
    logic [2:0]                size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_mem_type_e      msg_type;
  } bp_bedrock_mem_header_s;

  localparam int hdr_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic {
    e_cmd_idle,
    e_cmd_wdata
  } bp_me_dma_arb_cmd_state_e;

  typedef enum logic {
    e_resp_hdr,
    e_resp_data
  } bp_me_dma_arb_resp_state_e;

endpackage

`define DECLARE_BP_ME_DMA_ARB_TAG_S(sid_w) \
  typedef struct packed { \
    logic [sid_w-1:0] slice_id; \
    logic             is_read; \
  } bp_me_dma_arb_tag_s

// File: rtl/bp_me_cache_dma_resp_router.sv
// Response FSM: steers downstream response headers and read data beats to
// the slice named by the head of the in-order tag FIFO.
//   clk, reset                     : clock, synchronous active-high reset
//   fifo_v, head_slice_id,
//   head_is_read, deq              : tag FIFO head and dequeue strobe
//   mem_resp_header_v/_ready       : downstream header handshake
//   mem_resp_data_v/_ready         : downstream data handshake
//   slice_resp_header_v/_ready     : per-slice header handshake
//   slice_resp_data_v/_ready       : per-slice data handshake
module bp_me_cache_dma_resp_router
  import bp_me_cache_dma_arbiter_pkg::*;
#(
  parameter int num_slices_p = 2,
  parameter int beats_p      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fifo_v,
  input  logic [$clog2(num_slices_p)-1:0] head_slice_id,
  input  logic                            head_is_read,
  output logic                            deq,
  input  logic                            mem_resp_header_v,
  output logic                            mem_resp_header_ready,
  input  logic                            mem_resp_data_v,
  output logic                            mem_resp_data_ready,
  output logic [num_slices_p-1:0]         slice_resp_header_v,
  input  logic [num_slices_p-1:0]         slice_resp_header_ready,
  output logic [num_slices_p-1:0]         slice_resp_data_v,
  input  logic [num_slices_p-1:0]         slice_resp_data_ready
);

  localparam int beat_w_lp = (beats_p > 1) ? $clog2(beats_p) : 1;

  bp_me_dma_arb_resp_state_e state_r;
  logic [beat_w_lp-1:0]      beat_r;
  logic [num_slices_p-1:0]   sel;
  logic                      in_hdr, in_data, hdr_hs, data_hs, last_beat;

  assign sel       = {{(num_slices_p-1){1'b0}}, 1'b1} << head_slice_id;
  assign in_hdr    = ~reset & (state_r == e_resp_hdr);
  assign in_data   = ~reset & (state_r == e_resp_data);
  assign last_beat = (beat_r == beat_w_lp'(beats_p-1));

  assign slice_resp_header_v   = (in_hdr & mem_resp_header_v & fifo_v) ? sel : '0;
  assign mem_resp_header_ready = in_hdr & fifo_v & slice_resp_header_ready[head_slice_id];
  assign hdr_hs                = mem_resp_header_v & mem_resp_header_ready;

  // The head tag stays valid for the whole data phase, so no fifo_v term here.
  assign slice_resp_data_v   = (in_data & mem_resp_data_v) ? sel : '0;
  assign mem_resp_data_ready = in_data & slice_resp_data_ready[head_slice_id];
  assign data_hs             = mem_resp_data_v & mem_resp_data_ready;

  // Writes retire on their header; reads retire on the last data beat.
  assign deq = (hdr_hs & ~head_is_read) | (data_hs & last_beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= e_resp_hdr;
      beat_r  <= '0;
    end else begin
      case (state_r)
        e_resp_hdr: begin
          if (hdr_hs && head_is_read) state_r <= e_resp_data;
        end
        e_resp_data: begin
          if (data_hs) begin
            if (last_beat) begin
              beat_r  <= '0;
              state_r <= e_resp_hdr;
            end else begin
              beat_r <= beat_r + 1'b1;
            end
          end
        end
        default: state_r <= e_resp_hdr;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means memory and slices disagree.
  always_ff @(posedge clk) begin
    if (!reset && state_r == e_resp_hdr)
      assert (!(mem_resp_header_v && !fifo_v))
        else $error("response header arrived with no outstanding command");
  end
`endif

endmodule

// File: rtl/bp_me_cache_dma_arbiter.sv
// Shares one DRAM DMA channel among num_slices_p cache slices. Command
// headers are granted round-robin; write data beats stay locked to the
// winning slice. Responses return in order and are steered back through an
// in-order tag FIFO.
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   slice_cmd_header_*/data_*       : per-slice command header and write data
//   slice_resp_header_*/data_*      : broadcast response payload, one-hot valid
//   mem_cmd_header_*/data_*         : downstream command stream
//   mem_resp_header_*/data_*        : downstream response stream
module bp_me_cache_dma_arbiter
  import bp_me_cache_dma_arbiter_pkg::*;
#(
  parameter int num_slices_p      = 2,
  parameter int outstanding_p     = 4,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_slices_p*hdr_width_gp-1:0]  slice_cmd_header_i,
  input  logic [num_slices_p-1:0]               slice_cmd_header_v_i,
  output logic [num_slices_p-1:0]               slice_cmd_header_yumi_o,
  input  logic [num_slices_p*dword_width_p-1:0] slice_cmd_data_i,
  input  logic [num_slices_p-1:0]               slice_cmd_data_v_i,
  output logic [num_slices_p-1:0]               slice_cmd_data_yumi_o,
  output logic [hdr_width_gp-1:0]               slice_resp_header_o,
  output logic [num_slices_p-1:0]               slice_resp_header_v_o,
  input  logic [num_slices_p-1:0]               slice_resp_header_ready_i,
  output logic [dword_width_p-1:0]              slice_resp_data_o,
  output logic [num_slices_p-1:0]               slice_resp_data_v_o,
  input  logic [num_slices_p-1:0]               slice_resp_data_ready_i,
  output logic [hdr_width_gp-1:0]               mem_cmd_header_o,
  output logic                                  mem_cmd_header_v_o,
  input  logic                                  mem_cmd_header_yumi_i,
  output logic [dword_width_p-1:0]              mem_cmd_data_o,
  output logic                                  mem_cmd_data_v_o,
  input  logic                                  mem_cmd_data_yumi_i,
  input  logic [hdr_width_gp-1:0]               mem_resp_header_i,
  input  logic                                  mem_resp_header_v_i,
  output logic                                  mem_resp_header_ready_o,
  input  logic [dword_width_p-1:0]              mem_resp_data_i,
  input  logic                                  mem_resp_data_v_i,
  output logic                                  mem_resp_data_ready_o
);

  localparam int beats_lp  = cce_block_width_p / dword_width_p;
  localparam int sid_w_lp  = $clog2(num_slices_p);
  localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int ptr_w_lp  = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp  = $clog2(outstanding_p + 1);

  `DECLARE_BP_ME_DMA_ARB_TAG_S(sid_w_lp);

  bp_me_dma_arb_cmd_state_e cmd_state_r;
  logic [sid_w_lp-1:0]      rr_ptr_r, grant, rr_idx, gnt_r;
  logic                     found;
  logic [beat_w_lp-1:0]     wbeat_r;
  bp_bedrock_mem_header_s   cmd_hdr;
  logic                     is_read, enq, deq, in_wdata;

  bp_me_dma_arb_tag_s       tag_mem [outstanding_p];
  bp_me_dma_arb_tag_s       head;
  logic [ptr_w_lp-1:0]      wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]      cnt_r;
  logic                     fifo_v, fifo_full;

  // Round-robin: first valid slice at or after the pointer.
  always_comb begin
    grant  = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int i = 0; i < num_slices_p; i++) begin
      rr_idx = sid_w_lp'((int'(rr_ptr_r) + i) % num_slices_p);
      if (!found && slice_cmd_header_v_i[rr_idx]) begin
        grant = rr_idx;
        found = 1'b1;
      end
    end
  end

  assign cmd_hdr  = slice_cmd_header_i[int'(grant)*hdr_width_gp +: hdr_width_gp];
  assign is_read  = (cmd_hdr.msg_type == e_bedrock_mem_rd);

  // A dequeue frees a slot in the same cycle, so a full FIFO can still accept.
  assign mem_cmd_header_o        = cmd_hdr;
  assign mem_cmd_header_v_o      = ~reset_i & (cmd_state_r == e_cmd_idle)
                                   & (|slice_cmd_header_v_i) & (~fifo_full | deq);
  assign enq                     = mem_cmd_header_v_o & mem_cmd_header_yumi_i;
  assign slice_cmd_header_yumi_o = enq ? ({{(num_slices_p-1){1'b0}}, 1'b1} << grant) : '0;

  assign in_wdata              = ~reset_i & (cmd_state_r == e_cmd_wdata);
  assign mem_cmd_data_o        = slice_cmd_data_i[int'(gnt_r)*dword_width_p +: dword_width_p];
  assign mem_cmd_data_v_o      = in_wdata & slice_cmd_data_v_i[gnt_r];
  assign slice_cmd_data_yumi_o = (in_wdata & mem_cmd_data_yumi_i)
                                 ? ({{(num_slices_p-1){1'b0}}, 1'b1} << gnt_r) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_state_r <= e_cmd_idle;
      rr_ptr_r    <= '0;
      gnt_r       <= '0;
      wbeat_r     <= '0;
    end else begin
      case (cmd_state_r)
        e_cmd_idle: begin
          if (enq) begin
            rr_ptr_r <= (grant == sid_w_lp'(num_slices_p-1)) ? '0 : grant + 1'b1;
            if (!is_read) begin
              gnt_r       <= grant;
              cmd_state_r <= e_cmd_wdata;
            end
          end
        end
        e_cmd_wdata: begin
          if (mem_cmd_data_yumi_i) begin
            if (wbeat_r == beat_w_lp'(beats_lp-1)) begin
              wbeat_r     <= '0;
              cmd_state_r <= e_cmd_idle;
            end else begin
              wbeat_r <= wbeat_r + 1'b1;
            end
          end
        end
        default: cmd_state_r <= e_cmd_idle;
      endcase
    end
  end

  // In-order tag FIFO; storage needs no reset since the count gates it.
  assign fifo_v    = (cnt_r != '0);
  assign fifo_full = (cnt_r == cnt_w_lp'(outstanding_p));
  assign head      = tag_mem[rptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w_lp'(outstanding_p-1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(outstanding_p-1)) ? '0 : rptr_r + 1'b1;
      if (enq && !deq)      cnt_r <= cnt_r + 1'b1;
      else if (deq && !enq) cnt_r <= cnt_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) tag_mem[wptr_r] <= '{slice_id: grant, is_read: is_read};
  end

  assign slice_resp_header_o = mem_resp_header_i;
  assign slice_resp_data_o   = mem_resp_data_i;

  bp_me_cache_dma_resp_router #(
    .num_slices_p(num_slices_p),
    .beats_p     (beats_lp)
  ) resp_router (
    .clk                    (clk_i),
    .reset                  (reset_i),
    .fifo_v                 (fifo_v),
    .head_slice_id          (head.slice_id),
    .head_is_read           (head.is_read),
    .deq                    (deq),
    .mem_resp_header_v      (mem_resp_header_v_i),
    .mem_resp_header_ready  (mem_resp_header_ready_o),
    .mem_resp_data_v        (mem_resp_data_v_i),
    .mem_resp_data_ready    (mem_resp_data_ready_o),
    .slice_resp_header_v    (slice_resp_header_v_o),
    .slice_resp_header_ready(slice_resp_header_ready_i),
    .slice_resp_data_v      (slice_resp_data_v_o),
    .slice_resp_data_ready  (slice_resp_data_ready_i)
  );

endmodule

// File: doc/bp_me_cache_dma_arbiter.md
Name: bp_me_cache_dma_arbiter

Overview:
Shares one DRAM DMA channel (header + dword data streams, both directions) among num_slices_p L2 cache slices. Commands are granted round-robin, and write data beats stay locked to the winning slice. Responses return in order and are steered back to the issuing slice using an in-order tag FIFO. It sits between the cache slices' DMA-side ports and the memory controller or DRAM wormhole adapter.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, cce_block_width_p, dword_width_p and the dram bedrock header width (hdr_w below).
num_slices_p, 2, number of cache slices sharing the channel; must be ≥2.
outstanding_p, 4, depth of the response-routing tag FIFO (maximum commands in flight).
beats_lp (local), cce_block_width_p/dword_width_p, data beats per block (8 at the default configuration).

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
slice_cmd_header_i  in  num_slices_p*hdr_w  per-slice dram mem_cmd header
slice_cmd_header_v_i  in  num_slices_p  header valid
slice_cmd_header_yumi_o  out  num_slices_p  header consumed
slice_cmd_data_i  in  num_slices_p*dword_width_p  per-slice write data
slice_cmd_data_v_i  in  num_slices_p  data valid
slice_cmd_data_yumi_o  out  num_slices_p  data consumed
slice_resp_header_o  out  hdr_w  response header, broadcast to all slices
slice_resp_header_v_o  out  num_slices_p  one-hot header valid
slice_resp_header_ready_i  in  num_slices_p  slice header ready
slice_resp_data_o  out  dword_width_p  response data, broadcast to all slices
slice_resp_data_v_o  out  num_slices_p  one-hot data valid
slice_resp_data_ready_i  in  num_slices_p  slice data ready
mem_cmd_header_o  out  hdr_w  downstream command header
mem_cmd_header_v_o  out  1  command header valid
mem_cmd_header_yumi_i  in  1  command header consumed
mem_cmd_data_o  out  dword_width_p  downstream write data
mem_cmd_data_v_o  out  1  write data valid
mem_cmd_data_yumi_i  in  1  write data consumed
mem_resp_header_i  in  hdr_w  downstream response header
mem_resp_header_v_i  in  1  response header valid
mem_resp_header_ready_o  out  1  response header ready
mem_resp_data_i  in  dword_width_p  downstream read data
mem_resp_data_v_i  in  1  read data valid
mem_resp_data_ready_o  out  1  read data ready

Behaviour:
- Reset: every v_o, yumi_o and ready_o is 0. Both FSMs are in their idle state, beat counters are 0, the tag FIFO is empty and the round-robin pointer favours slice 0.
- Downstream contract: one response header per command, returned in command order. A read response carries beats_lp data beats. A write response is header only.
- Command FSM, e_cmd_idle:
  - grant = round-robin over slice_cmd_header_v_i.
  - mem_cmd_header_v_o = |slice_cmd_header_v_i & ~fifo_full; the header is muxed from the grant.
  - On mem_cmd_header_yumi_i: pulse slice_cmd_header_yumi_o[grant], enqueue tag {slice_id, is_read = (msg_type==e_bedrock_mem_rd)}, advance the pointer past the grant.
  - If the command is a write, register grant→gnt_r and go to e_cmd_wdata.
- Command FSM, e_cmd_wdata:
  - mem_cmd_data_o/v_o come from slice gnt_r; slice_cmd_data_yumi_o[gnt_r] = mem_cmd_data_yumi_i.
  - Count beats; on the yumi of beat beats_lp-1, clear the counter and return to e_cmd_idle.
  - No header is granted while in this state.
- Data yumi outside e_cmd_wdata is always 0. Data valid from a non-granted slice is ignored.
- Response FSM, e_resp_hdr:
  - slice_resp_header_v_o = onehot(head.slice_id) & {mem_resp_header_v_i & fifo_v}.
  - mem_resp_header_ready_o = fifo_v & slice_resp_header_ready_i[head.slice_id].
  - On handshake: for a write, dequeue and stay in e_resp_hdr; for a read, go to e_resp_data.
- Response FSM, e_resp_data:
  - Data routes the same way to head.slice_id; mem_resp_data_ready_o = slice_resp_data_ready_i[head.slice_id].
  - Count beats; on the handshake of the last beat, dequeue, clear the counter and return to e_resp_hdr.
- mem_resp_data_ready_o is 0 outside e_resp_data.
- FIFO empty: mem_resp_header_ready_o = 0. A response header with the FIFO empty is a protocol error, flagged by a simulation-only assertion.
- FIFO full: mem_cmd_header_v_o = 0 until a dequeue. Enqueue and dequeue in the same cycle are legal, including when full.
- Command path and response path run independently; read data returns while write data issues.
- Reset mid-transfer: both FSMs return to idle next cycle and all tags are dropped; the system must reset slices and memory together.
- Latency: zero-cycle combinational pass-through on every handshake; no added bubbles between beats.

Decomposition:
- Shared package (bp_me_pkg): FSM enums bp_me_dma_arb_cmd_state_e and bp_me_dma_arb_resp_state_e; macro declaring the tag struct {slice_id [log2(num_slices_p)], is_read}.
- Reuse: bsg_arb_round_robin, bsg_fifo_1r1w_small (tags), bsg_counter_clear_up (beats).
- One natural sub-module: bp_me_cache_dma_resp_router (response FSM plus steering, fed by the FIFO head).

Test Plan:
- Single read, slice 1: header out, tag {1,rd} queued; 8 response beats delivered only on slice_resp_data_v_o = 2'b10; FIFO empty afterwards.
- Single write, slice 0: header then 8 data beats, each with slice_cmd_data_yumi_o = 2'b01; slice 1 data valid held high throughout and never yumied; write-response header reaches slice 0.
- Both slices assert reads every cycle: grants alternate 0,1,0,1; responses are steered in the same order.
- FIFO full (outstanding_p = 4 reads, no responses): mem_cmd_header_v_o = 0; after one response completes, the next header issues in the same cycle as the dequeue.
- Back-pressure: slice 0 drops slice_resp_data_ready_i on beat 3; mem_resp_data_ready_o drops the same cycle; the beat count resumes correctly; a slice 1 write issues concurrently.
- Reset asserted during beat 5 of a write: the next cycle shows all valids 0 and both FSMs idle; a fresh read afterwards completes normally.
